// File: rtl/mul_exec_datapath.sv
// mul_exec_datapath: registered state plus 32x32 signed radix-4 Booth datapath, one step per EXEC cycle.
// Ports: clk, reset_n (async active-low), op_clear (sync clear), op_start (capture in IDLE),
//   multiplicand/multiplier (signed operands), next_state (from next-state logic) ->
//   state, exec_count_out (Booth step index), result (signed product), op_done (state==DONE).
// Optional: MUL_ZERO_SKIP_EN finishes zero-operand products after one EXEC cycle.
module mul_exec_datapath #(
  parameter int         WIDTH = 32,
  parameter logic [1:0] IDLE  = 2'b00,
  parameter logic [1:0] EXEC  = 2'b01,
  parameter logic [1:0] DONE  = 2'b10
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_clear,
  input  logic               op_start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [1:0]         next_state,
  output logic [1:0]         state,
  output logic [3:0]         exec_count_out,
  output logic [2*WIDTH-1:0] result,
  output logic               op_done
);
  localparam int AW = WIDTH + 2;
  logic [1:0]         state_q;
  logic [3:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d, q_q, q_d;
  logic [AW-1:0]      a_q, a_d, m_ext, addend, sum;
  logic               qm1_q, qm1_d, skip_q, skip_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [AW+WIDTH:0]  shifted;
  logic [2:0]         sel;
  logic               capture, exec, zero;
`ifdef MUL_ZERO_SKIP_EN
  // q_q still holds the original multiplier before the first step
  assign zero = state_q == EXEC && !op_clear && cnt_q == 4'd0 && (m_q == '0 || q_q == '0);
`else
  assign zero = 1'b0;
`endif
  always_comb begin
    capture = state_q == IDLE && op_start && !op_clear;
    exec    = state_q == EXEC && !op_clear;
    m_ext   = {{2{m_q[WIDTH-1]}}, m_q};
    sel     = {q_q[1:0], qm1_q};
    addend  = (sel == 3'b001 || sel == 3'b010) ? m_ext :
              sel == 3'b011 ? m_ext << 1 :
              sel == 3'b100 ? -(m_ext << 1) :
              (sel == 3'b101 || sel == 3'b110) ? -m_ext : '0;
    sum     = a_q + addend;
    shifted = $signed({sum, q_q, qm1_q}) >>> 2;
    m_d     = capture ? multiplicand : m_q;
    a_d     = (op_clear || capture) ? '0 : exec ? shifted[AW+WIDTH:WIDTH+1] : a_q;
    q_d     = op_clear ? '0 : capture ? multiplier : exec ? shifted[WIDTH:1] : q_q;
    qm1_d   = (op_clear || capture) ? 1'b0 : exec ? shifted[0] : qm1_q;
    cnt_d   = zero ? 4'hf : exec ? cnt_q + 4'd1 : 4'd0;
    skip_d  = zero;
    res_d   = (op_clear || zero) ? '0 :
              (exec && cnt_q == 4'hf && !skip_q) ? shifted[2*WIDTH:1] : res_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      skip_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= next_state;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      skip_q  <= skip_d;
      res_q   <= res_d;
    end
  end
  assign state          = state_q;
  assign exec_count_out = cnt_q;
  assign result         = res_q;
  assign op_done        = state_q == DONE;
endmodule

// File: tb/tb_mul_exec_datapath.sv
// tb_mul_exec_datapath: scoreboard bench with next-state model and signed-product reference.
module tb_mul_exec_datapath;
  localparam logic [1:0] IDLE = 2'b00, EXEC = 2'b01, DONE = 2'b10;
`ifdef MUL_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 0, reset_n = 0, op_clear = 0, op_start = 0;
  logic [31:0] multiplicand = 0, multiplier = 0;
  logic [1:0] next_state, state;
  logic [3:0] exec_count_out;
  logic [63:0] result;
  logic op_done;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {logic [63:0] res; int done_cyc; int start_cyc; bit zero;} exp_t;
  exp_t sb[$];

  mul_exec_datapath dut (
    .clk(clk), .reset_n(reset_n), .op_clear(op_clear), .op_start(op_start),
    .multiplicand(multiplicand), .multiplier(multiplier), .next_state(next_state),
    .state(state), .exec_count_out(exec_count_out), .result(result), .op_done(op_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb
    next_state = op_clear ? IDLE :
                 state == IDLE ? (op_start ? EXEC : IDLE) :
                 exec_count_out == 4'hf ? DONE :
                 state == EXEC ? EXEC : IDLE;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int k;
    logic [3:0] e;
    exp_t x;
    if (reset_n) begin
      chk("op_done_decode", {63'd0, op_done}, {63'd0, state == DONE});
      if (state != EXEC) chk("count_outside_exec", {63'd0, exec_count_out == 4'hf}, 64'd0);
      if (state == EXEC && sb.size() != 0) begin
        k = cyc - sb[0].start_cyc - 1;
        e = (SKIP && sb[0].zero) ? (k == 0 ? 4'd0 : 4'hf) : k[3:0];
        chk("exec_count", {60'd0, exec_count_out}, {60'd0, e});
      end
      if (op_done) begin
        if (sb.size() == 0) chk("unexpected_done", {63'd0, op_done}, 64'd0);
        else begin
          x = sb.pop_front();
          chk("result", result, x.res);
          chk("done_cycle", 64'(cyc), 64'(x.done_cyc));
        end
      end
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    bit z;
    @(negedge clk);
    z = (a == 0 || b == 0);
    multiplicand = a;
    multiplier = b;
    op_start = 1;
    x.res = longint'($signed(a)) * longint'($signed(b));
    x.start_cyc = cyc;
    x.done_cyc = cyc + ((SKIP && z) ? 3 : 17);
    x.zero = z;
    sb.push_back(x);
    @(negedge clk);
    op_start = 0;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("done_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic wait_count(input logic [3:0] k);
    for (int i = 0; i < 40 && exec_count_out != k; i++) @(negedge clk);
    chk("wait_count", {60'd0, exec_count_out}, {60'd0, k});
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_state"}, {62'd0, state}, 64'd0);
    chk({name, "_count"}, {60'd0, exec_count_out}, 64'd0);
    chk({name, "_result"}, result, 64'd0);
    chk({name, "_done"}, {63'd0, op_done}, 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    repeat (2) begin
      @(negedge clk);
      chk_zero("reset");
    end
    reset_n = 1;
    repeat (5) begin
      @(negedge clk);
      chk_zero("idle");
    end
    start(32'd7, -32'sd3);
    wait_done();
    @(negedge clk);
    chk("held_idle_state", {62'd0, state}, 64'd0);
    chk("held_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
    start(32'h8000_0000, 32'h8000_0000);
    wait_done();
    chk("minmin_result", result, 64'h4000_0000_0000_0000);
    start(32'h7FFF_FFFF, 32'h8000_0000);
    wait_done();
    chk("maxmin_result", result, 64'hC000_0000_8000_0000);
    start(32'd5, 32'd6);
    wait_count(4'd7);
    op_clear = 1;
    @(posedge clk);
    #1 op_clear = 0;
    sb.delete();
    @(negedge clk);
    chk_zero("clear");
    repeat (20) @(negedge clk);
    start(32'd3, 32'd4);
    wait_count(4'd4);
    multiplicand = 32'd99;
    multiplier = 32'd77;
    op_start = 1;
    @(negedge clk);
    op_start = 0;
    wait_done();
    chk("ignored_start_result", result, 64'd12);
    start(32'd11, 32'd13);
    wait_count(4'd9);
    #2 reset_n = 0;
    #1 chk_zero("async_reset");
    sb.delete();
    @(negedge clk);
    chk_zero("reset_hold");
    reset_n = 1;
    start(32'd0, 32'h1234);
    wait_done();
    chk("zero_result", result, 64'd0);
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 5) == 0) a = 0;
      if ($urandom_range(0, 5) == 0) b = 0;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
      start(a, b);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    start(32'd9, 32'd9);
    wait_done();
    @(negedge clk);
    op_clear = 1;
    op_start = 1;
    multiplicand = 32'd2;
    multiplier = 32'd2;
    @(negedge clk);
    op_clear = 0;
    op_start = 0;
    chk("clear_start_state", {62'd0, state}, 64'd0);
    chk("clear_start_result", result, 64'd0);
    repeat (3) @(negedge clk);
    chk("clear_start_still_idle", {62'd0, state}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_exec_datapath.md
Name: mul_exec_datapath

Overview:
- Sits directly downstream of the multiplier's next-state logic.
- Registers `next_state` into `state` and returns `state` to the next-state logic.
- Runs a 32x32 signed radix-4 Booth multiplication, one step per EXEC cycle.
- Drives `exec_count_out` back to the next-state logic's `exec_count_in`; the next-state logic moves to DONE when that count reaches 4'b1111.

Parameters:
- WIDTH, 32, operand width. Only 32 is legal: 16 Booth steps map onto the 4-bit exec count.
- IDLE, 2'b00, state encoding.
- EXEC, 2'b01, state encoding.
- DONE, 2'b10, state encoding.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- op_clear  input  1  synchronous clear, priority over everything except reset_n.
- op_start  input  1  start request; sampled only when state==IDLE.
- multiplicand  input  WIDTH  signed operand M.
- multiplier  input  WIDTH  signed operand Q.
- next_state  input  2  from the next-state logic.
- state  output  2  registered current state.
- exec_count_out  output  4  Booth step index.
- result  output  2*WIDTH  signed product, registered.
- op_done  output  1  high while state==DONE.

Behaviour:
- One clock domain.
- reset_n low (asynchronous), all outputs and internal registers cleared:
  - state=IDLE, exec_count_out=0, result=0, op_done=0.
  - Internal M register, accumulator and q_-1 cleared to 0.
- Each rising edge: state <= next_state. No other state decoding in this block.
- op_clear=1 at an edge: exec_count_out, result and accumulator go to 0. State follows next_state, which is IDLE.
- Operand capture: at an edge with state==IDLE and op_start==1 (and op_clear==0):
  - M <= multiplicand.
  - Accumulator upper part A (WIDTH+2 bits) <= 0.
  - Lower part <= multiplier.
  - q_-1 <= 0.
  - exec_count_out <= 0.
- op_start outside IDLE is ignored; operands are never re-latched mid-operation.
- EXEC, each edge performs one Booth step:
  - Examine {Q[1],Q[0],q_-1}:
    - 000 or 111: +0
    - 001 or 010: +M
    - 011: +2M
    - 100: -2M
    - 101 or 110: -M
  - M is sign-extended to WIDTH+2 bits before add/sub; the add is two's-complement modulo 2^(WIDTH+2).
  - Then arithmetic shift right by 2 of {A,Q,q_-1}: A's sign bit is replicated, and the old Q[1] becomes the new q_-1.
- Counter:
  - In EXEC, exec_count_out increments by 1 per edge.
  - 4'b1111 wraps to 0 at the edge that performs step 15.
  - Outside EXEC it is held at 0, except at operand capture, where it is also 0.
  - It must never read 4'b1111 outside EXEC: the next-state logic treats 1111 as "go to DONE" regardless of state.
- Result load: at the edge performing step 15 (count==15), result <= {A[WIDTH-1:0], Q} taken after the shift.
  - result holds through DONE and IDLE until the next step-15 edge, op_clear, or reset.
- Latency from op_start sampled in IDLE:
  - 16 EXEC cycles (counts 0..15), then 1 DONE cycle with op_done=1, then IDLE.
  - Total: 17 cycles from the start edge to op_done.
- op_done = (state==DONE), decoded from the state register; high for exactly 1 cycle per operation.
- reset_n asserted mid-EXEC: the operation is aborted immediately and result reads 0.
- Simultaneous op_clear and op_start in IDLE: op_clear wins, nothing is captured.
- Illegal state 2'b11 (next_state x or 11): counter held 0, datapath idle. This block performs no recovery; the next-state logic drives it back.

Optional Feature:
- Macro MUL_ZERO_SKIP_EN.
- Defined:
  - In the first EXEC cycle (count==0), if M==0 or the original multiplier==0, result <= 0 and exec_count_out <= 4'b1111.
  - The next cycle shows count 15, and the next-state logic goes to DONE.
  - EXEC lasts 2 cycles; op_done appears 3 cycles after the start edge.
  - result is not reloaded at that count-15 edge.
- Undefined: zero operands take the full 16 Booth steps. The result is still 0.

Test Plan:
- Reset low for 2 cycles, then high, idle 5 cycles -> state=00, exec_count_out=0, result=0, op_done=0 throughout.
- M=7, Q=-3, op_start pulse in IDLE -> exec_count_out steps 0..15 over 16 EXEC cycles, then op_done=1 for one cycle with result=0xFFFF_FFFF_FFFF_FFEB, then IDLE with result held.
- M=0x8000_0000, Q=0x8000_0000 -> result=0x4000_0000_0000_0000. Then M=0x7FFF_FFFF, Q=0x8000_0000 -> result=0xC000_0000_8000_0000.
- Start M=5, Q=6; op_clear=1 when exec_count_out==7 -> next cycle state=IDLE, exec_count_out=0, result=0, op_done never asserted.
- Start M=3, Q=4; at count 4 change multiplicand/multiplier and pulse op_start -> ignored, result=12. Separately, reset_n low at count 9 -> all outputs 0 asynchronously.
- M=0, Q=0x1234: with MUL_ZERO_SKIP_EN -> EXEC 2 cycles (count 0 then 15), op_done on the 3rd cycle, result=0. Without the macro -> 16 EXEC cycles, result=0.
